// File: rtl/voxguard_pkg.sv
// Shared definitions for the voice RX deframer: sync word, seed length,
// checksum width and the deframer FSM encoding.
package voxguard_pkg;

    localparam logic [15:0] SYNC_WORD  = 16'hCAFE;
    localparam int          SEED_BYTES = 4;
    localparam int          CSUM_W     = 8;

    typedef enum logic [2:0] {
        ST_HUNT_HI,
        ST_HUNT_LO,
        ST_SEED,
        ST_PAY_HI,
        ST_PAY_LO,
        ST_CHECK
    } rx_state_e;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [8:0] b);
        logic [9:0] s;
        s = {2'b00, a} + {1'b0, b};
        return (s > 10'd255) ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/rx_word_fifo.sv
// 16-bit word FIFO with synchronous flush; a push into a full FIFO succeeds
// only when a pop happens in the same cycle.
module rx_word_fifo #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [15:0]   data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [15:0]   data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/voice_rx_deframer.sv
// Hunts CAFE sync, captures the chaotic seed and reassembles ciphertext words
// into a FIFO. Define RX_CHECKSUM_EN to expect a trailing XOR checksum byte.
module voice_rx_deframer
    import voxguard_pkg::*;
#(
    parameter int PAYLOAD_WORDS  = 32,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_byte,
    input  logic        rx_byte_valid,
    output logic [15:0] payload_data,
    output logic        payload_valid,
    input  logic        payload_ready,
    output logic        next_key_en,
    output logic        sync_en,
    output logic [31:0] sync_state_out,
    output logic        locked,
    output logic        frame_done,
    output logic        frame_err,
    output logic [7:0]  drop_cnt
);

    localparam int WCW = $clog2(PAYLOAD_WORDS + 1);
    localparam int GW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    rx_state_e      state_q, state_d;
    logic [1:0]     seed_cnt_q, seed_cnt_d;
    logic [23:0]    seed_sh_q, seed_sh_d;
    logic [31:0]    sync_state_q, sync_state_d;
    logic           sync_en_q, sync_en_d, locked_q, locked_d;
    logic           frame_done_q, frame_done_d, frame_err_q, frame_err_d;
    logic [7:0]     hi_q, hi_d, drop_q, drop_d;
    logic [15:0]    word_q, word_d;
    logic           push_q, push_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic [GW-1:0]  gap_q, gap_d;
`ifdef RX_CHECKSUM_EN
    logic [CSUM_W-1:0] csum_q, csum_d;
`endif

    logic          flush, pop, fifo_full, fifo_empty, hunting, timeout, push_drop;
    logic [CW-1:0] fifo_cnt, flush_drop;

    // Pops are held off while the new seed is being presented so the
    // keystream is re-seeded before any word consumes it.
    assign payload_valid  = !fifo_empty && !sync_en_q;
    assign pop            = payload_valid && payload_ready;
    assign next_key_en    = pop;
    assign sync_en        = sync_en_q;
    assign sync_state_out = sync_state_q;
    assign locked         = locked_q;
    assign frame_done     = frame_done_q;
    assign frame_err      = frame_err_q;
    assign drop_cnt       = drop_q;

    assign hunting    = (state_q == ST_HUNT_HI) || (state_q == ST_HUNT_LO);
    assign timeout    = !rx_byte_valid && !hunting && (gap_q == GW'(TIMEOUT_CYCLES - 1));
    assign push_drop  = push_q && fifo_full && !pop;
    assign flush_drop = flush ? (fifo_cnt - CW'(pop)) : '0;

    rx_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_q),
        .data_i  (word_q),
        .pop_i   (pop),
        .flush_i (flush),
        .data_o  (payload_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_comb begin
        state_d      = state_q;
        seed_cnt_d   = seed_cnt_q;
        seed_sh_d    = seed_sh_q;
        sync_state_d = sync_state_q;
        sync_en_d    = 1'b0;
        locked_d     = locked_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        hi_d         = hi_q;
        word_d       = word_q;
        push_d       = 1'b0;
        word_cnt_d   = word_cnt_q;
        flush        = 1'b0;
`ifdef RX_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        gap_d  = (rx_byte_valid || hunting) ? '0 : gap_q + 1'b1;
        drop_d = sat_add8(drop_q, 9'(flush_drop) + 9'(push_drop));

        if (timeout) begin
            state_d     = ST_HUNT_HI;
            frame_err_d = 1'b1;
            locked_d    = 1'b0;
        end else if (rx_byte_valid) begin
            case (state_q)
                ST_HUNT_HI: if (rx_byte == SYNC_WORD[15:8]) state_d = ST_HUNT_LO;
                ST_HUNT_LO: begin
                    seed_cnt_d = '0;
                    if (rx_byte == SYNC_WORD[7:0])       state_d = ST_SEED;
                    else if (rx_byte != SYNC_WORD[15:8]) state_d = ST_HUNT_HI;
                end
                ST_SEED: begin
                    seed_sh_d  = {seed_sh_q[15:0], rx_byte};
                    seed_cnt_d = seed_cnt_q + 1'b1;
                    if (seed_cnt_q == 2'(SEED_BYTES - 1)) begin
                        sync_state_d = {seed_sh_q, rx_byte};
                        sync_en_d    = 1'b1;
                        locked_d     = 1'b1;
                        flush        = 1'b1;
                        word_cnt_d   = '0;
`ifdef RX_CHECKSUM_EN
                        csum_d       = '0;
`endif
                        state_d      = ST_PAY_HI;
                    end
                end
                ST_PAY_HI: begin
                    hi_d    = rx_byte;
`ifdef RX_CHECKSUM_EN
                    csum_d  = csum_q ^ rx_byte;
`endif
                    state_d = ST_PAY_LO;
                end
                ST_PAY_LO: begin
                    word_d     = {hi_q, rx_byte};
                    push_d     = 1'b1;
                    word_cnt_d = word_cnt_q + 1'b1;
`ifdef RX_CHECKSUM_EN
                    csum_d     = csum_q ^ rx_byte;
`endif
                    if (word_cnt_q == WCW'(PAYLOAD_WORDS - 1)) begin
`ifdef RX_CHECKSUM_EN
                        state_d      = ST_CHECK;
`else
                        state_d      = ST_HUNT_HI;
                        frame_done_d = 1'b1;
                        locked_d     = 1'b0;
`endif
                    end else begin
                        state_d = ST_PAY_HI;
                    end
                end
`ifdef RX_CHECKSUM_EN
                ST_CHECK: begin
                    frame_done_d = (rx_byte == csum_q);
                    frame_err_d  = (rx_byte != csum_q);
                    locked_d     = 1'b0;
                    state_d      = ST_HUNT_HI;
                end
`endif
                default: state_d = ST_HUNT_HI;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HUNT_HI;
            seed_cnt_q   <= '0;
            seed_sh_q    <= '0;
            sync_state_q <= '0;
            sync_en_q    <= 1'b0;
            locked_q     <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            hi_q         <= '0;
            word_q       <= '0;
            push_q       <= 1'b0;
            word_cnt_q   <= '0;
            gap_q        <= '0;
            drop_q       <= '0;
`ifdef RX_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            seed_cnt_q   <= seed_cnt_d;
            seed_sh_q    <= seed_sh_d;
            sync_state_q <= sync_state_d;
            sync_en_q    <= sync_en_d;
            locked_q     <= locked_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            hi_q         <= hi_d;
            word_q       <= word_d;
            push_q       <= push_d;
            word_cnt_q   <= word_cnt_d;
            gap_q        <= gap_d;
            drop_q       <= drop_d;
`ifdef RX_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_voice_rx_deframer.sv
// Scoreboard bench for voice_rx_deframer: directed frames push expected words,
// a negedge monitor compares every popped word and counts control pulses.
module tb_voice_rx_deframer;

    localparam int PW = 32;
    localparam int FD = 8;
    localparam int TO = 200;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [7:0]  rx_byte = '0;
    logic        rx_byte_valid = 1'b0, payload_ready = 1'b0;
    logic [15:0] payload_data;
    logic        payload_valid, next_key_en, sync_en, locked, frame_done, frame_err;
    logic [31:0] sync_state_out;
    logic [7:0]  drop_cnt;

    voice_rx_deframer #(.PAYLOAD_WORDS(PW), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
        .payload_data(payload_data), .payload_valid(payload_valid), .payload_ready(payload_ready),
        .next_key_en(next_key_en), .sync_en(sync_en), .sync_state_out(sync_state_out),
        .locked(locked), .frame_done(frame_done), .frame_err(frame_err), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    logic [15:0] exp_q[$];
    int exp_drop = 0, sync_cnt = 0, done_cnt = 0, err_cnt = 0, nk_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (sync_en) begin
                sync_cnt++;
                chk("sync_cycle_no_pop", {30'd0, payload_valid, next_key_en}, 32'd0);
            end
            if (frame_done) done_cnt++;
            if (frame_err)  err_cnt++;
            if (next_key_en) nk_cnt++;
            if (payload_valid && payload_ready) begin
                chk("next_key_en_on_pop", {31'd0, next_key_en}, 32'd1);
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL pop_unexpected: got %04h want none", payload_data);
                end else begin
                    chk("pop_data", {16'd0, payload_data}, {16'd0, exp_q.pop_front()});
                end
            end else if (next_key_en) begin
                n_vec++; n_err++;
                $display("FAIL next_key_en_spurious: got 1 want 0");
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte = b; rx_byte_valid = 1'b1;
        @(posedge clk); #1;
        rx_byte_valid = 1'b0;
    endtask

    task automatic model_push(input logic [15:0] w);
        if (!payload_ready && exp_q.size() >= FD) exp_drop++;
        else exp_q.push_back(w);
    endtask

    task automatic send_header(input logic [31:0] seed);
        send(8'hCA); send(8'hFE);
        send(seed[31:24]); send(seed[23:16]); send(seed[15:8]);
        exp_drop += exp_q.size();
        exp_q.delete();
        send(seed[7:0]);
    endtask

    task automatic send_payload(input logic [15:0] base, input logic [7:0] corrupt);
        logic [15:0] w;
        logic [7:0]  cs;
        cs = 8'h00;
        for (int i = 0; i < PW; i++) begin
            w = base + 16'(i);
            send(w[15:8]); send(w[7:0]);
            cs = cs ^ w[15:8] ^ w[7:0];
            model_push(w);
        end
`ifdef RX_CHECKSUM_EN
        send(cs ^ corrupt);
`else
        if (corrupt != 8'h00 && cs == 8'h00) $display("note: corrupt ignored");
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        chk("rst_outputs", {26'd0, payload_valid, next_key_en, sync_en, locked, frame_done, frame_err}, 32'd0);
        chk("rst_sync_state", sync_state_out, 32'd0);
        chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // 1) basic frame, consumer always ready
        payload_ready = 1'b1;
        send_header(32'h12345678);
        chk("t1_locked", {31'd0, locked}, 32'd1);
        chk("t1_seed", sync_state_out, 32'h12345678);
        send_payload(16'h0001, 8'h00);
        idle(4);
        chk("t1_done", done_cnt, 1);
        chk("t1_sync", sync_cnt, 1);
        chk("t1_nk", nk_cnt, 32);
        chk("t1_unlocked", {31'd0, locked}, 32'd0);
        chk("t1_drop", {24'd0, drop_cnt}, 32'd0);

        // 2) noisy preamble locks; CA 00 FE does not
        send(8'h00); send(8'hCA);
        send_header(32'hA5A50001);
        chk("t2_locked", {31'd0, locked}, 32'd1);
        chk("t2_seed", sync_state_out, 32'hA5A50001);
        send_payload(16'h0100, 8'h00);
        send(8'hCA); send(8'h00); send(8'hFE); send(8'h11);
        idle(3);
        chk("t2_nolock", {31'd0, locked}, 32'd0);
        chk("t2_sync", sync_cnt, 2);
        chk("t2_done", done_cnt, 2);

        // 3) consumer stalled for whole frame
        payload_ready = 1'b0;
        send_header(32'hDEADBEEF);
        send_payload(16'h0001, 8'h00);
        idle(3);
        chk("t3_valid", {31'd0, payload_valid}, 32'd1);
        chk("t3_head", {16'd0, payload_data}, 32'h0001);
        chk("t3_drop", {24'd0, drop_cnt}, 32'd24);
        chk("t3_done", done_cnt, 3);

        // 5) drain 3, then new frame flushes the remaining 5
        payload_ready = 1'b1;
        idle(3);
        payload_ready = 1'b0;
        chk("t5_nk_before", nk_cnt, 67);
        send_header(32'h0BADF00D);
        chk("t5_drop_flush", {24'd0, drop_cnt}, 32'd29);
        chk("t5_drop_model", {24'd0, drop_cnt}, exp_drop);
        chk("t5_sync_en_now", {31'd0, sync_en}, 32'd1);
        payload_ready = 1'b1;
        send_payload(16'h0200, 8'h00);
        idle(4);
        chk("t5_done", done_cnt, 4);
        chk("t5_sync", sync_cnt, 4);
        chk("t5_nk", nk_cnt, 99);

        // 4) timeout mid-word, then clean relock
        send_header(32'h11112222);
        send(8'hAB); send(8'hCD); model_push(16'hABCD); send(8'hEF);
        idle(TO - 3);
        chk("t4_still_locked", {31'd0, locked}, 32'd1);
        chk("t4_no_err_yet", err_cnt, 0);
        idle(8);
        chk("t4_err", err_cnt, 1);
        chk("t4_unlocked", {31'd0, locked}, 32'd0);
        send_header(32'h33334444);
        chk("t4_relock", {31'd0, locked}, 32'd1);
        send_payload(16'h0300, 8'h00);
        idle(4);
        chk("t4_done", done_cnt, 5);
        chk("t4_sync", sync_cnt, 6);
        chk("t4_nk", nk_cnt, 132);

`ifdef RX_CHECKSUM_EN
        // 6) corrupted checksum trailer
        send_header(32'h55556666);
        send_payload(16'h0400, 8'h01);
        idle(4);
        chk("t6_err", err_cnt, 2);
        chk("t6_no_done", done_cnt, 5);
        chk("t6_unlocked", {31'd0, locked}, 32'd0);
`endif

        idle(4);
        chk("queue_drained", exp_q.size(), 0);
        chk("final_drop", {24'd0, drop_cnt}, exp_drop);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
